pinlock_n: RTL and testbench
============================

# pinlock_n

Parameterised electronic PIN lock, the next generation of the keypad lock controller. Accepts keypad strobes, stores a PIN of configurable length, then gates the `lock` output on matching re-entry. Adds a backspace key, explicit enter-to-compare, a failed-attempt counter with timed lockout, and tick-based timeouts. Sits between the keypad scanner (`keycode`/`keyenbl`) and the 7-segment display driver and lock actuator.

## Interface
- PIN_LEN, 4: PIN digits, 1..8.
- MAX_FAIL, 3: consecutive mismatches that trigger LOCKOUT, 1..15.
- TIMEOUT_TICKS, 128: ticks without an accepted key before an input state aborts, 2..255.
- SHOW_TICKS, 16: ticks spent in MATCH or FAIL, 2..255.
- LOCKOUT_TICKS, 255: ticks spent in LOCKOUT, 2..255.
- ck  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- tick  input  1  one-cycle timebase enable (nominally 32 Hz).
- keycode  input  4  key value: 0x0-0x9 digit, 0xD delete, 0xE enter, 0xC close.
- keyenbl  input  1  single-cycle strobe qualifying `keycode`.
- lock  output  1  1 = locked.
- state  output  3  current FSM state.
- digits  output  4*PIN_LEN  entry buffer; nibble 0 is the newest digit, unused nibbles 0xF.
- dispen  output  PIN_LEN  per-nibble display enable.
- failcnt  output  4  consecutive mismatch count.

## Operation
- States: HALT=0, MEMIN=1, OPEN=2, CLOSED=3, SECIN=4, MATCH=5, FAIL=6, LOCKOUT=7.
- Entry buffer holds `cnt` digits (0..PIN_LEN).
- A digit key with cnt<PIN_LEN shifts in at nibble 0, moves older nibbles up, and increments cnt.
- A digit key with cnt==PIN_LEN is ignored.
- Delete with cnt>0 shifts the buffer down, fills the top nibble with 0xF, and decrements cnt. Delete with cnt==0 is ignored.
- Timer: counts `tick`. It clears on every accepted key and on every state change.
- Timeout fires when the timer reaches the state's limit on a tick.
- HALT: a digit key loads the digit and moves to MEMIN. Other keys are ignored.
- MEMIN:
  - digit/delete edit the buffer.
  - Enter with cnt==PIN_LEN copies the buffer to the secret, clears the buffer, and moves to OPEN.
  - Enter with cnt<PIN_LEN is ignored.
  - TIMEOUT_TICKS timeout clears the buffer and moves to HALT.
- OPEN: lock=0. Close clears the buffer and moves to CLOSED. Other keys are ignored.
- CLOSED: lock=1. A digit key loads the digit and moves to SECIN.
- SECIN:
  - digit/delete edit the buffer.
  - Enter with cnt==PIN_LEN compares the buffer to the secret. Equal moves to MATCH. Unequal moves to FAIL and increments failcnt, saturating at 15.
  - Enter with cnt<PIN_LEN is ignored.
  - Timeout clears the buffer and moves to CLOSED; failcnt is unchanged.
- MATCH: lock=0 from entry. After SHOW_TICKS it clears the buffer, sets failcnt=0, and moves to OPEN.
- FAIL: after SHOW_TICKS it clears the buffer. It moves to LOCKOUT if failcnt>=MAX_FAIL, else to CLOSED.
- LOCKOUT: all keys are ignored. After LOCKOUT_TICKS it sets failcnt=0 and moves to CLOSED.
- Keys are ignored in MATCH, FAIL and LOCKOUT, and the timer is not cleared by them.
- dispen:
  - MEMIN/SECIN: bit i=1 iff i<cnt.
  - MATCH/FAIL: all ones while timer[1]=1, else all zeros.
  - Other states: all zeros.
- digits is driven in every state.

## Timing
- All outputs are registered. `state`, `digits`, `cnt`, `failcnt` and `lock` update on the ck edge that samples keyenbl=1, so latency is 1 cycle.
- `lock` rises on the edge entering CLOSED and falls on the edge entering MATCH.
- Timeout transition occurs on the edge sampling the limiting tick.
- Key and timeout in the same cycle: the key wins; its action applies and the timer clears.
- keyenbl while tick=1: the key is processed and the timer clears, with no increment.
- Reset values: state=HALT, lock=0, digits all 0xF, dispen=0, failcnt=0, cnt=0, timer=0, secret all 0xF.
- Reset mid-operation forgets the secret.
- Unused state encodings return to HALT on the next edge.

## Test plan
- PIN_LEN=4: keys 1,2,3,4,E -> OPEN, lock=0; key C -> CLOSED, lock=1 one cycle later; keys 1,2,3,4,E -> MATCH, lock=0; after 16 ticks -> OPEN.
- MEMIN keys 1,2,D,5,6,7,E -> secret 0x1567. Enter after only 3 digits is ignored (state stays MEMIN). A 5th digit is ignored.
- CLOSED with secret 0x1234, wrong PIN 9,9,9,9,E three times -> failcnt 1,2,3. The third FAIL leads to LOCKOUT. Keys are ignored for 255 ticks, then CLOSED with failcnt=0.
- SECIN with 2 digits and no key for 128 ticks -> CLOSED, digits all 0xF, failcnt unchanged. MEMIN timeout -> HALT.
- Key and the 128th tick in the same cycle -> key accepted, no timeout. Reset asserted in SECIN -> HALT, lock=0, secret all 0xF asynchronously.
- PIN_LEN=1 and PIN_LEN=8 each: full store/close/match cycle passes; dispen width and bits track cnt.

Source files
------------

// File: rtl/pinlock_n_if.sv
// Keypad/display/actuator bundle for the pinlock_n controller.
// The bench (master) drives keypad and timebase; the lock (slave) drives status and display.
interface pinlock_n_if #(
  parameter int PIN_LEN = 4
);
  logic                   tick;
  logic [3:0]             keycode;
  logic                   keyenbl;
  logic                   lock;
  logic [2:0]             state;
  logic [4*PIN_LEN-1:0]   digits;
  logic [PIN_LEN-1:0]     dispen;
  logic [3:0]             failcnt;

  modport master (
    output tick, keycode, keyenbl,
    input  lock, state, digits, dispen, failcnt
  );

  modport slave (
    input  tick, keycode, keyenbl,
    output lock, state, digits, dispen, failcnt
  );
endinterface

// File: rtl/pinlock_n.sv
// Parameterised PIN lock: store a PIN, then unlock on matching re-entry, with
// backspace, enter-to-compare, failed-attempt lockout and tick-based timeouts.
module pinlock_n #(
  parameter int PIN_LEN       = 4,
  parameter int MAX_FAIL      = 3,
  parameter int TIMEOUT_TICKS = 128,
  parameter int SHOW_TICKS    = 16,
  parameter int LOCKOUT_TICKS = 255
) (
  input logic        ck,
  input logic        reset,
  pinlock_n_if.slave bus
);
  localparam int            DW       = 4 * PIN_LEN;
  localparam logic [DW-1:0] BLANK    = '1;
  localparam logic [3:0]    FULL     = 4'(PIN_LEN);
  localparam logic [3:0]    MAXF     = 4'(MAX_FAIL);
  localparam logic [7:0]    TO_LIM   = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    SHOW_LIM = 8'(SHOW_TICKS - 1);
  localparam logic [7:0]    LOCK_LIM = 8'(LOCKOUT_TICKS - 1);

  typedef enum logic [2:0] {
    HALT    = 3'd0,
    MEMIN   = 3'd1,
    OPEN    = 3'd2,
    CLOSED  = 3'd3,
    SECIN   = 3'd4,
    MATCH   = 3'd5,
    FAIL    = 3'd6,
    LOCKOUT = 3'd7
  } state_t;

  state_t             state_q, state_n;
  logic [DW-1:0]      entry_q, entry_n;
  logic [DW-1:0]      secret_q, secret_n;
  logic [3:0]         cnt_q, cnt_n;
  logic [3:0]         failcnt_q, failcnt_n;
  logic [7:0]         timer_q, timer_n;
  logic               lock_q, lock_n;
  logic [PIN_LEN-1:0] dispen_q, dispen_n;
  logic               key_taken;
  logic               is_digit, is_del, is_ent, is_close;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic limit_hit(input logic t, input logic [7:0] tmr,
                                     input logic [7:0] lim);
    return t && (tmr == lim);
  endfunction

  assign is_digit = bus.keyenbl && (bus.keycode <= 4'd9);
  assign is_del   = bus.keyenbl && (bus.keycode == 4'hD);
  assign is_ent   = bus.keyenbl && (bus.keycode == 4'hE);
  assign is_close = bus.keyenbl && (bus.keycode == 4'hC);

  always_comb begin
    state_n   = state_q;
    entry_n   = entry_q;
    secret_n  = secret_q;
    cnt_n     = cnt_q;
    failcnt_n = failcnt_q;
    key_taken = 1'b0;
    case (state_q)
      HALT, CLOSED: begin
        if (is_digit) begin
          entry_n = (BLANK << 4) | DW'(bus.keycode);
          cnt_n   = 4'd1;
          state_n = (state_q == HALT) ? MEMIN : SECIN;
        end
      end
      MEMIN, SECIN: begin
        key_taken = bus.keyenbl;
        if (is_digit) begin
          if (cnt_q < FULL) begin
            entry_n = (entry_q << 4) | DW'(bus.keycode);
            cnt_n   = cnt_q + 4'd1;
          end
        end else if (is_del) begin
          if (cnt_q != 4'd0) begin
            entry_n = (entry_q >> 4) | (BLANK << (DW - 4));
            cnt_n   = cnt_q - 4'd1;
          end
        end else if (is_ent) begin
          if (cnt_q == FULL) begin
            if (state_q == MEMIN) begin
              secret_n = entry_q;
              entry_n  = BLANK;
              cnt_n    = 4'd0;
              state_n  = OPEN;
            end else if (entry_q == secret_q) begin
              state_n = MATCH;
            end else begin
              failcnt_n = sat_inc4(failcnt_q);
              state_n   = FAIL;
            end
          end
        end else if (!bus.keyenbl && limit_hit(bus.tick, timer_q, TO_LIM)) begin
          // Abandoned entry: drop the partial PIN and fall back a step.
          entry_n = BLANK;
          cnt_n   = 4'd0;
          state_n = (state_q == MEMIN) ? HALT : CLOSED;
        end
      end
      OPEN: begin
        if (is_close) begin
          entry_n = BLANK;
          cnt_n   = 4'd0;
          state_n = CLOSED;
        end
      end
      MATCH: begin
        if (limit_hit(bus.tick, timer_q, SHOW_LIM)) begin
          entry_n   = BLANK;
          cnt_n     = 4'd0;
          failcnt_n = 4'd0;
          state_n   = OPEN;
        end
      end
      FAIL: begin
        if (limit_hit(bus.tick, timer_q, SHOW_LIM)) begin
          entry_n = BLANK;
          cnt_n   = 4'd0;
          state_n = (failcnt_q >= MAXF) ? LOCKOUT : CLOSED;
        end
      end
      LOCKOUT: begin
        if (limit_hit(bus.tick, timer_q, LOCK_LIM)) begin
          failcnt_n = 4'd0;
          state_n   = CLOSED;
        end
      end
      default: state_n = HALT;
    endcase
  end

  // Timer and registered outputs follow the next state so they change on the same edge.
  always_comb begin
    timer_n = timer_q;
    if ((state_n != state_q) || key_taken)
      timer_n = 8'd0;
    else if (bus.tick && (timer_q != 8'hFF))
      timer_n = timer_q + 8'd1;

    lock_n = (state_n == CLOSED) || (state_n == SECIN) ||
             (state_n == FAIL)   || (state_n == LOCKOUT);

    dispen_n = '0;
    if ((state_n == MEMIN) || (state_n == SECIN)) begin
      for (int i = 0; i < PIN_LEN; i++)
        dispen_n[i] = (i < int'(cnt_n));
    end else if ((state_n == MATCH) || (state_n == FAIL)) begin
      dispen_n = {PIN_LEN{timer_n[1]}};
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q   <= HALT;
      entry_q   <= BLANK;
      secret_q  <= BLANK;
      cnt_q     <= 4'd0;
      failcnt_q <= 4'd0;
      timer_q   <= 8'd0;
      lock_q    <= 1'b0;
      dispen_q  <= '0;
    end else begin
      state_q   <= state_n;
      entry_q   <= entry_n;
      secret_q  <= secret_n;
      cnt_q     <= cnt_n;
      failcnt_q <= failcnt_n;
      timer_q   <= timer_n;
      lock_q    <= lock_n;
      dispen_q  <= dispen_n;
    end
  end

  assign bus.state   = state_q;
  assign bus.lock    = lock_q;
  assign bus.digits  = entry_q;
  assign bus.dispen  = dispen_q;
  assign bus.failcnt = failcnt_q;
endmodule

// File: tb/tb_pinlock_n.sv
// Scoreboard bench for pinlock_n: three instances (PIN_LEN 1, 4, 8) share clock, reset and tick.
// Stimulus queues expected values stamped with the cycle they become visible; a monitor checks them.
module tb_pinlock_n;
  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  logic       ck = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] keycode;
  logic       keyenbl;
  int         sel;

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  pinlock_n_if #(.PIN_LEN(1)) b1 ();
  pinlock_n_if #(.PIN_LEN(4)) b4 ();
  pinlock_n_if #(.PIN_LEN(8)) b8 ();

  assign b1.tick = tick;  assign b1.keycode = keycode;  assign b1.keyenbl = keyenbl && (sel == 1);
  assign b4.tick = tick;  assign b4.keycode = keycode;  assign b4.keyenbl = keyenbl && (sel == 4);
  assign b8.tick = tick;  assign b8.keycode = keycode;  assign b8.keyenbl = keyenbl && (sel == 8);

  pinlock_n #(.PIN_LEN(1)) u1 (.ck(ck), .reset(reset), .bus(b1));
  pinlock_n #(.PIN_LEN(4)) u4 (.ck(ck), .reset(reset), .bus(b4));
  pinlock_n #(.PIN_LEN(8)) u8 (.ck(ck), .reset(reset), .bus(b8));

  // fields: 0 state, 1 lock, 2 digits, 3 dispen, 4 failcnt, 5 secret (PIN_LEN=4 only)
  function automatic logic [31:0] actual(input int d, input int f);
    logic [31:0] r;
    r = '0;
    case (d)
      1: case (f)
           0: r = 32'(b1.state);   1: r = 32'(b1.lock);   2: r = 32'(b1.digits);
           3: r = 32'(b1.dispen);  4: r = 32'(b1.failcnt); default: r = 'x;
         endcase
      4: case (f)
           0: r = 32'(b4.state);   1: r = 32'(b4.lock);   2: r = 32'(b4.digits);
           3: r = 32'(b4.dispen);  4: r = 32'(b4.failcnt); 5: r = 32'(u4.secret_q);
           default: r = 'x;
         endcase
      8: case (f)
           0: r = 32'(b8.state);   1: r = 32'(b8.lock);   2: r = 32'(b8.digits);
           3: r = 32'(b8.dispen);  4: r = 32'(b8.failcnt); default: r = 'x;
         endcase
      default: r = 'x;
    endcase
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ck);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        logic [31:0] a;
        e = sb.pop_front();
        a = actual(e.dut, e.fld);
        compared++;
        if (a !== e.val) begin
          mismatched++;
          $display("FAIL %s (u%0d f%0d cyc %0d): got %0h expected %0h",
                   e.nm, e.dut, e.fld, cyc, a, e.val);
        end
      end
    end
  end

  task automatic chk(input int d, input int f, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.fld = f; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic st(input int d, input int s, input int l, input int fc, input string nm);
    chk(d, 0, 32'(s), {nm, "_state"});
    chk(d, 1, 32'(l), {nm, "_lock"});
    chk(d, 4, 32'(fc), {nm, "_failcnt"});
  endtask

  task automatic key(input int d, input logic [3:0] k);
    @(posedge ck); #1;
    sel = d; keycode = k; keyenbl = 1'b1;
    @(posedge ck); #1;
    keyenbl = 1'b0;
  endtask

  task automatic keyt(input int d, input logic [3:0] k);
    @(posedge ck); #1;
    sel = d; keycode = k; keyenbl = 1'b1; tick = 1'b1;
    @(posedge ck); #1;
    keyenbl = 1'b0; tick = 1'b0;
  endtask

  task automatic keyseq(input int d, input logic [31:0] v, input int n);
    logic [31:0] w;
    w = v;
    for (int i = n - 1; i >= 0; i--) key(d, w[4*i +: 4]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck); #1; tick = 1'b1;
      @(posedge ck); #1; tick = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge ck); #1; reset = 1'b1;
    @(posedge ck); #1; reset = 1'b0;
  endtask

  initial begin : stim
    reset = 1'b1; tick = 1'b0; keyenbl = 1'b0; keycode = 4'h0; sel = 0;
    repeat (3) @(posedge ck);
    #1 reset = 1'b0;
    st(1, 0, 0, 0, "rst1"); chk(1, 2, 32'hF, "rst1_digits"); chk(1, 3, 0, "rst1_dispen");
    st(4, 0, 0, 0, "rst4"); chk(4, 2, 32'hFFFF, "rst4_digits"); chk(4, 3, 0, "rst4_dispen");
    st(8, 0, 0, 0, "rst8"); chk(8, 2, 32'hFFFFFFFF, "rst8_digits"); chk(8, 3, 0, "rst8_dispen");

    // PIN_LEN=1 full cycle
    key(1, 4'h7); chk(1, 0, 1, "u1_memin"); chk(1, 2, 32'h7, "u1_dig"); chk(1, 3, 1, "u1_dispen");
    key(1, 4'hE); st(1, 2, 0, 0, "u1_open"); chk(1, 2, 32'hF, "u1_clr"); chk(1, 3, 0, "u1_dispen0");
    key(1, 4'hC); st(1, 3, 1, 0, "u1_closed");
    key(1, 4'h7); chk(1, 0, 4, "u1_secin"); chk(1, 3, 1, "u1_sec_dispen");
    key(1, 4'hE); st(1, 5, 0, 0, "u1_match"); chk(1, 3, 0, "u1_match_dispen0");
    ticks(2);  chk(1, 0, 5, "u1_match_hold"); chk(1, 3, 1, "u1_blink");
    ticks(13); chk(1, 0, 5, "u1_match_15");
    ticks(1);  st(1, 2, 0, 0, "u1_reopen");

    // PIN_LEN=8 full cycle
    keyseq(8, 32'h123, 3); chk(8, 0, 1, "u8_memin"); chk(8, 2, 32'hFFFFF123, "u8_dig3");
    chk(8, 3, 32'h07, "u8_dispen3");
    keyseq(8, 32'h45678, 5); chk(8, 2, 32'h12345678, "u8_dig8"); chk(8, 3, 32'hFF, "u8_dispen8");
    key(8, 4'hE); st(8, 2, 0, 0, "u8_open");
    key(8, 4'hC); st(8, 3, 1, 0, "u8_closed");
    keyseq(8, 32'h12345678, 8); chk(8, 0, 4, "u8_secin"); chk(8, 3, 32'hFF, "u8_sec_dispen");
    key(8, 4'hE); st(8, 5, 0, 0, "u8_match");
    ticks(16); st(8, 2, 0, 0, "u8_reopen");

    // PIN_LEN=4 editing: 1,2,D,5,6,E(ignored),7,8(ignored),E -> secret 1567
    keyseq(4, 32'h12, 2); chk(4, 2, 32'hFF12, "ed_12"); chk(4, 3, 32'h3, "ed_dispen2");
    key(4, 4'hD); chk(4, 2, 32'hFFF1, "ed_del"); chk(4, 3, 32'h1, "ed_dispen1");
    keyseq(4, 32'h56, 2); chk(4, 2, 32'hF156, "ed_156");
    key(4, 4'hE); chk(4, 0, 1, "ed_short_enter"); chk(4, 2, 32'hF156, "ed_short_keep");
    key(4, 4'h7); chk(4, 2, 32'h1567, "ed_1567"); chk(4, 3, 32'hF, "ed_dispen4");
    key(4, 4'h8); chk(4, 2, 32'h1567, "ed_5th_ignored");
    key(4, 4'hE); st(4, 2, 0, 0, "ed_open"); chk(4, 2, 32'hFFFF, "ed_clr");
    chk(4, 5, 32'h1567, "ed_secret");
    key(4, 4'hC); st(4, 3, 1, 0, "ed_closed");
    keyseq(4, 32'h1567, 4); key(4, 4'hE); st(4, 5, 0, 0, "ed_match");
    ticks(16); chk(4, 0, 2, "ed_reopen");

    // Reset forgets the secret; store 1234 and run the basic flow
    pulse_reset(); chk(4, 0, 0, "r_halt"); chk(4, 5, 32'hFFFF, "r_secret");
    keyseq(4, 32'h1234, 4); key(4, 4'hE); st(4, 2, 0, 0, "b_open");
    key(4, 4'hC); st(4, 3, 1, 0, "b_closed");
    keyseq(4, 32'h1234, 4); key(4, 4'hE); st(4, 5, 0, 0, "b_match");
    ticks(15); chk(4, 0, 5, "b_match_15");
    ticks(1);  st(4, 2, 0, 0, "b_reopen");

    // Three wrong attempts -> lockout
    key(4, 4'hC); chk(4, 0, 3, "f_closed");
    for (int n = 1; n <= 3; n++) begin
      keyseq(4, 32'h9999, 4); key(4, 4'hE); st(4, 6, 1, n, "f_fail");
      ticks(16); chk(4, 0, (n < 3) ? 3 : 7, "f_after_show"); chk(4, 2, 32'hFFFF, "f_clr");
    end
    chk(4, 1, 1, "lo_lock");
    key(4, 4'h1); chk(4, 0, 7, "lo_key_ignored"); chk(4, 2, 32'hFFFF, "lo_digits");
    ticks(254); chk(4, 0, 7, "lo_254");
    ticks(1);   st(4, 3, 1, 0, "lo_done");

    // SECIN timeout keeps failcnt
    keyseq(4, 32'h9999, 4); key(4, 4'hE); ticks(16); st(4, 3, 1, 1, "t_fc1");
    keyseq(4, 32'h12, 2); chk(4, 0, 4, "t_secin"); chk(4, 3, 32'h3, "t_dispen");
    ticks(127); chk(4, 0, 4, "t_127");
    ticks(1);   st(4, 3, 1, 1, "t_timeout"); chk(4, 2, 32'hFFFF, "t_clr"); chk(4, 3, 0, "t_dispen0");

    // Key coinciding with the limiting tick wins and restarts the timer
    keyseq(4, 32'h12, 2); ticks(127);
    keyt(4, 4'h3); chk(4, 0, 4, "kt_state"); chk(4, 2, 32'hF123, "kt_digits"); chk(4, 3, 32'h7, "kt_dispen");
    ticks(127); chk(4, 0, 4, "kt_127");
    ticks(1);   chk(4, 0, 3, "kt_timeout");

    // Asynchronous reset in SECIN
    keyseq(4, 32'h12, 2); st(4, 4, 1, 1, "ar_secin");
    @(posedge ck); #1; reset = 1'b1; #1;
    st(4, 0, 0, 0, "ar"); chk(4, 5, 32'hFFFF, "ar_secret"); chk(4, 2, 32'hFFFF, "ar_digits");
    @(posedge ck); #1; reset = 1'b0;

    // MEMIN timeout
    key(4, 4'h5); chk(4, 0, 1, "mt_memin");
    ticks(127); chk(4, 0, 1, "mt_127");
    ticks(1);   chk(4, 0, 0, "mt_halt"); chk(4, 2, 32'hFFFF, "mt_clr");

    repeat (3) @(posedge ck);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
